multicycle_control: RTL and testbench

Multicycle control sequencer for the MIPS core. It replaces the single-cycle "advance PC every clock" behaviour with a state machine that steps each instruction through fetch, decode, execute, memory and writeback over several cycles. It drives every datapath control strobe: PC update, IR load, register-file write, memory read/write, and the ALU and mux selects. It waits on a memory-ready handshake, counts retired instructions, and traps on unsupported opcodes.

---
 rtl/multicycle_control.sv | 155 +++++++++++++++
 tb/tb_multicycle_control.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, trap on bad opcodes, retire count.
// lw 5, sw/R/addi 4, beq/j 3 cycles; every mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state_q, state_d;

  // zero only qualifies pcwritecond inside the datapath; the FSM never branches on it
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset masks every strobe combinationally so an in-flight access drops at once
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR, S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcsource    = 2'b01;
          pcwritecond = 1'b1;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // An instruction retires on the edge that returns the FSM to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      retired <= '0;
    else if (state_d == S_FETCH && state_q != S_FETCH)
      retired <= retired + CNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector table plus hand sequences for trap hold, reset mid-store and counter wrap.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;

  logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic        memtoreg, regdst, regwrite, alusrca, illegal;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        s_pcwrite, s_pcwritecond, s_iord, s_memread, s_memwrite, s_irwrite;
  logic        s_memtoreg, s_regdst, s_regwrite, s_alusrca, s_illegal;
  logic [1:0]  s_alusrcb, s_aluop, s_pcsource;
  logic [3:0]  s_state;
  logic [1:0]  s_retired;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal(illegal), .state(state), .retired(retired)
  );

  // Narrow counter instance sees identical stimulus; it exercises the wrap
  multicycle_control #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(s_pcwrite), .pcwritecond(s_pcwritecond), .iord(s_iord), .memread(s_memread),
    .memwrite(s_memwrite), .irwrite(s_irwrite), .memtoreg(s_memtoreg), .regdst(s_regdst),
    .regwrite(s_regwrite), .alusrca(s_alusrca), .alusrcb(s_alusrcb), .aluop(s_aluop),
    .pcsource(s_pcsource), .illegal(s_illegal), .state(s_state), .retired(s_retired)
  );

  logic [16:0] ctl;
  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal};

  localparam logic [16:0] B_PCW   = 17'h10000;
  localparam logic [16:0] B_PCWC  = 17'h08000;
  localparam logic [16:0] B_IORD  = 17'h04000;
  localparam logic [16:0] B_MRD   = 17'h02000;
  localparam logic [16:0] B_MWR   = 17'h01000;
  localparam logic [16:0] B_IRW   = 17'h00800;
  localparam logic [16:0] B_M2R   = 17'h00400;
  localparam logic [16:0] B_RDST  = 17'h00200;
  localparam logic [16:0] B_RW    = 17'h00100;
  localparam logic [16:0] B_SRCA  = 17'h00080;
  localparam logic [16:0] B_SRCB1 = 17'h00020;   // alusrcb = 01
  localparam logic [16:0] B_SRCB2 = 17'h00040;   // alusrcb = 10
  localparam logic [16:0] B_OPSUB = 17'h00008;   // aluop = 01
  localparam logic [16:0] B_OPFN  = 17'h00010;   // aluop = 10
  localparam logic [16:0] B_PCS1  = 17'h00002;   // pcsource = 01
  localparam logic [16:0] B_PCS2  = 17'h00004;   // pcsource = 10
  localparam logic [16:0] B_ILL   = 17'h00001;

  localparam logic [16:0] C_NONE   = 17'h0;
  localparam logic [16:0] C_FETCHW = B_MRD | B_SRCB1;
  localparam logic [16:0] C_FETCHR = B_MRD | B_SRCB1 | B_IRW | B_PCW;
  localparam logic [16:0] C_DEC    = B_SRCB1 | B_SRCB2;
  localparam logic [16:0] C_ADR    = B_SRCA | B_SRCB2;
  localparam logic [16:0] C_MEMRD  = B_MRD | B_IORD;
  localparam logic [16:0] C_MEMWR  = B_MWR | B_IORD;
  localparam logic [16:0] C_MEMWB  = B_RW | B_M2R;
  localparam logic [16:0] C_EXEC   = B_SRCA | B_OPFN;
  localparam logic [16:0] C_ALUWB  = B_RW | B_RDST;
  localparam logic [16:0] C_ADDIWB = B_RW;
  localparam logic [16:0] C_BRANCH = B_SRCA | B_OPSUB | B_PCS1 | B_PCWC;
  localparam logic [16:0] C_JUMP   = B_PCW | B_PCS2;
  localparam logic [16:0] C_TRAP   = B_ILL;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic        z;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [16:0] c, input logic [31:0] ret);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.z = z; v.st = st; v.ctl = c; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    //  rst  op     rdy  z    st     ctl       retired
    add(1, 6'h00, 1, 0, 4'd0,  C_NONE,   0);  // reset masks memread in FETCH
    add(0, 6'h00, 1, 0, 4'd0,  C_FETCHR, 0);  // R-type
    add(0, 6'h00, 0, 0, 4'd1,  C_DEC,    0);  // mem_ready ignored in DECODE
    add(0, 6'h3F, 1, 0, 4'd6,  C_EXEC,   0);  // opcode ignored in EXEC
    add(0, 6'h3F, 1, 0, 4'd7,  C_ALUWB,  0);
    add(0, 6'h23, 1, 0, 4'd0,  C_FETCHR, 1);  // lw, 2 wait cycles in MEMRD
    add(0, 6'h23, 1, 0, 4'd1,  C_DEC,    1);
    add(0, 6'h23, 1, 0, 4'd2,  C_ADR,    1);
    add(0, 6'h23, 0, 0, 4'd3,  C_MEMRD,  1);
    add(0, 6'h23, 0, 0, 4'd3,  C_MEMRD,  1);
    add(0, 6'h23, 1, 0, 4'd3,  C_MEMRD,  1);
    add(0, 6'h23, 1, 0, 4'd4,  C_MEMWB,  1);
    add(0, 6'h2B, 0, 0, 4'd0,  C_FETCHW, 2);  // sw, 3 wait cycles in FETCH
    add(0, 6'h2B, 0, 0, 4'd0,  C_FETCHW, 2);
    add(0, 6'h2B, 0, 0, 4'd0,  C_FETCHW, 2);
    add(0, 6'h2B, 1, 0, 4'd0,  C_FETCHR, 2);
    add(0, 6'h2B, 1, 0, 4'd1,  C_DEC,    2);
    add(0, 6'h2B, 1, 0, 4'd2,  C_ADR,    2);
    add(0, 6'h2B, 1, 0, 4'd5,  C_MEMWR,  2);
    add(0, 6'h04, 1, 0, 4'd0,  C_FETCHR, 3);  // beq
    add(0, 6'h04, 1, 0, 4'd1,  C_DEC,    3);
    add(0, 6'h3F, 1, 1, 4'd8,  C_BRANCH, 3);  // zero toggle has no FSM effect
    add(0, 6'h02, 1, 0, 4'd0,  C_FETCHR, 4);  // j
    add(0, 6'h02, 1, 0, 4'd1,  C_DEC,    4);
    add(0, 6'h02, 1, 0, 4'd9,  C_JUMP,   4);
    add(0, 6'h08, 1, 0, 4'd0,  C_FETCHR, 5);  // addi
    add(0, 6'h08, 1, 0, 4'd1,  C_DEC,    5);
    add(0, 6'h08, 1, 0, 4'd10, C_ADR,    5);
    add(0, 6'h08, 1, 0, 4'd11, C_ADDIWB, 5);
    add(0, 6'h3F, 1, 0, 4'd0,  C_FETCHR, 6);  // illegal opcode
    add(0, 6'h3F, 1, 0, 4'd1,  C_DEC,    6);
    add(0, 6'h00, 1, 0, 4'd12, C_TRAP,   6);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy; zero = vecs[i].z;
      #1;
      check($sformatf("row%0d state", i), {28'd0, state}, {28'd0, vecs[i].st});
      check($sformatf("row%0d ctl", i), {15'd0, ctl}, {15'd0, vecs[i].ctl});
      check($sformatf("row%0d retired", i), retired, vecs[i].ret);
      check($sformatf("row%0d retired_w2", i), {30'd0, s_retired}, {30'd0, vecs[i].ret[1:0]});
    end

    // TRAP holds for many cycles regardless of inputs
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      mem_ready = k[0]; opcode = 6'h00; zero = k[1];
      #1;
      check($sformatf("trap%0d state", k), {28'd0, state}, 32'd12);
      check($sformatf("trap%0d ctl", k), {15'd0, ctl}, {15'd0, C_TRAP});
      check($sformatf("trap%0d retired", k), retired, 32'd6);
    end

    // Reset asserted mid-cycle leaves TRAP at once
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("trap_reset illegal", {31'd0, illegal}, 32'd0);
    check("trap_reset state", {28'd0, state}, 32'd0);
    check("trap_reset retired", retired, 32'd0);

    // Store stalled in MEMWR, then reset between edges abandons the access
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'h2B;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw_wait state", {28'd0, state}, 32'd5);
    check("sw_wait memwrite", {31'd0, memwrite}, 32'd1);
    @(negedge clk);
    #1;
    check("sw_wait2 memwrite", {31'd0, memwrite}, 32'd1);
    check("sw_wait2 retired", retired, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("sw_reset memwrite", {31'd0, memwrite}, 32'd0);
    check("sw_reset iord", {31'd0, iord}, 32'd0);
    check("sw_reset state", {28'd0, state}, 32'd0);
    check("sw_reset retired", retired, 32'd0);

    // First fetch after release retires nothing until the instruction completes
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'h02;
    #1;
    check("post_reset ctl", {15'd0, ctl}, {15'd0, C_FETCHR});
    repeat (3) @(negedge clk);
    #1;
    check("post_reset j retired", retired, 32'd1);
    check("post_reset j state", {28'd0, state}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
